// File: rtl/mem_spi_bridge.sv
// SPI mode-0 slave bridging an external host to a small byte-wide memory.
// Decodes command frames, issues write pulses and streams registered read data out on MISO.
module mem_spi_bridge #(
  parameter int ADDR_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 spi_sclk,
  input  logic                 spi_cs_n,
  input  logic                 spi_mosi,
  output logic                 spi_miso,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [7:0]           mem_wdata,
  output logic                 mem_we,
  input  logic [7:0]           mem_rdata,
  output logic                 busy
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_CMD  = 3'd1;
  localparam logic [2:0] ST_WR   = 3'd2;
  localparam logic [2:0] ST_RD   = 3'd3;
  localparam logic [2:0] ST_IGN  = 3'd4;
  localparam logic [ADDR_BITS-1:0] ADDR_ONE = {{(ADDR_BITS-1){1'b0}}, 1'b1};

  logic                 sclk_s1_q, sclk_s2_q, sclk_s3_q;
  logic                 cs_s1_q, cs_s2_q, cs_prev_q;
  logic                 mosi_s1_q, mosi_s2_q;
  logic [1:0]           sync_ok_q;

  logic [2:0]           state_q, state_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [6:0]           rx_q, rx_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [7:0]           wdata_q, wdata_d;
  logic                 we_q, we_d;
  logic [1:0]           ld_q, ld_d;
  logic [7:0]           tx_q, tx_d;
  logic                 miso_q, miso_d;

  logic                 sclk_rise, sclk_fall, cs_fall, byte_done;
  logic [7:0]           rx_byte;

  // cs_prev is held low until the synchronizer carries real pin data, so a
  // chip select already low at reset release never looks like a frame start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_s1_q <= 1'b0;
      sclk_s2_q <= 1'b0;
      sclk_s3_q <= 1'b0;
      cs_s1_q   <= 1'b1;
      cs_s2_q   <= 1'b1;
      cs_prev_q <= 1'b0;
      mosi_s1_q <= 1'b0;
      mosi_s2_q <= 1'b0;
      sync_ok_q <= 2'b00;
    end else begin
      sclk_s1_q <= spi_sclk;
      sclk_s2_q <= sclk_s1_q;
      sclk_s3_q <= sclk_s2_q;
      cs_s1_q   <= spi_cs_n;
      cs_s2_q   <= cs_s1_q;
      cs_prev_q <= cs_s2_q & sync_ok_q[1];
      mosi_s1_q <= spi_mosi;
      mosi_s2_q <= mosi_s1_q;
      sync_ok_q <= {sync_ok_q[0], 1'b1};
    end
  end

  assign sclk_rise = sclk_s2_q & ~sclk_s3_q;
  assign sclk_fall = ~sclk_s2_q & sclk_s3_q;
  assign cs_fall   = cs_prev_q & ~cs_s2_q;
  assign rx_byte   = {rx_q, mosi_s2_q};
  assign byte_done = sclk_rise && (bit_cnt_q == 3'd7);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    ld_d      = {ld_q[0], 1'b0};
    tx_d      = tx_q;
    miso_d    = miso_q;

    // Post-write increment lands the cycle after the pulse.
    if (we_q) addr_d = addr_q + ADDR_ONE;
    // Read data is valid two cycles after the address moved.
    if (ld_q[1]) tx_d = mem_rdata;

    if (sclk_rise) begin
      rx_d      = {rx_q[5:0], mosi_s2_q};
      bit_cnt_d = bit_cnt_q + 3'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d   = ST_CMD;
          bit_cnt_d = 3'd0;
        end
      end
      ST_CMD: begin
        if (byte_done) begin
          if (rx_byte[6:4] != 3'b000) begin
            state_d = ST_IGN;
          end else begin
            addr_d = rx_byte[ADDR_BITS-1:0];
            if (rx_byte[7]) begin
              state_d = ST_WR;
            end else begin
              state_d = ST_RD;
              ld_d[0] = 1'b1;
            end
          end
        end
      end
      ST_WR: begin
        if (byte_done) begin
          wdata_d = rx_byte;
          we_d    = 1'b1;
        end
      end
      ST_RD: begin
        if (sclk_fall) begin
          miso_d = tx_q[7];
          tx_d   = {tx_q[6:0], 1'b0};
        end
        if (byte_done) begin
          addr_d  = addr_q + ADDR_ONE;
          ld_d[0] = 1'b1;
        end
      end
      ST_IGN: begin
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_q != ST_RD) miso_d = 1'b0;

    if (cs_s2_q) begin
      state_d = ST_IDLE;
      we_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= 3'd0;
      rx_q      <= 7'd0;
      addr_q    <= '0;
      wdata_q   <= 8'd0;
      we_q      <= 1'b0;
      ld_q      <= 2'b00;
      tx_q      <= 8'd0;
      miso_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      ld_q      <= ld_d;
      tx_q      <= tx_d;
      miso_q    <= miso_d;
    end
  end

  assign spi_miso  = miso_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = we_q;
  assign busy      = (state_q == ST_CMD) || (state_q == ST_WR) || (state_q == ST_RD);

endmodule

// File: tb/tb_mem_spi_bridge.sv
// Bench for mem_spi_bridge: bit-banged SPI host, 16-byte registered-read memory,
// and a frame-level model (shadow memory + expected write/read queues).
module tb_mem_spi_bridge;

  logic       clk;
  logic       rst_n;
  logic       spi_sclk;
  logic       spi_cs_n;
  logic       spi_mosi;
  logic       spi_miso;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic [7:0] mem_rdata;
  logic       busy;

  int checks = 0;
  int failures = 0;

  logic mon_en = 1'b0;
  logic chk_miso0 = 1'b0;
  logic mem_load = 1'b1;

  logic [7:0]  mem [16];
  logic [7:0]  mem_init [16];
  logic [7:0]  shadow [16];
  logic [7:0]  rxb [16];
  logic [11:0] exp_wr [$];
  logic [7:0]  exp_rd [$];
  logic [7:0]  tx_bytes [$];
  logic [11:0] e_wr;

  mem_spi_bridge #(.ADDR_BITS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .spi_sclk  (spi_sclk),
    .spi_cs_n  (spi_cs_n),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory being driven: registered read, write on mem_we.
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 16; i++) mem[i] <= mem_init[i];
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    mem_rdata <= mem[mem_addr];
  end

  // Every cycle: any write pulse must match the next expected write; MISO idle low when required.
  always @(negedge clk) begin
    if (mon_en) begin
      if (mem_we !== 1'b0) begin
        checks++;
        if (exp_wr.size() == 0) begin
          failures++;
          $display("FAIL unexpected_we actual addr=%0d data=%02h required no write", mem_addr, mem_wdata);
        end else begin
          e_wr = exp_wr.pop_front();
          if ({mem_addr, mem_wdata} !== e_wr) begin
            failures++;
            $display("FAIL write_pulse actual addr=%0d data=%02h required addr=%0d data=%02h",
                     mem_addr, mem_wdata, e_wr[11:8], e_wr[7:0]);
          end
        end
      end
      if (chk_miso0) begin
        checks++;
        if (spi_miso !== 1'b0) begin
          failures++;
          $display("FAIL miso_idle actual=%b required=0", spi_miso);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Sends nbits from tx_bytes as one frame. With use_model the expected writes/reads
  // are derived from the frame rules; otherwise the caller has queued literals.
  task automatic run_frame(input int nbits, input int half, input int rst_bit,
                           input bit exp_busy, input bit use_model);
    logic [7:0] cmd;
    logic [7:0] t;
    logic [3:0] a4;
    bit         valid;
    bit         is_rd;
    int         nfull;
    int         lim;
    cmd   = tx_bytes[0];
    valid = (cmd[6:4] == 3'b000);
    is_rd = valid && !cmd[7];
    nfull = (nbits - 8) / 8;
    if (rst_bit >= 0) begin
      lim = (rst_bit < 8) ? 0 : (rst_bit - 8) / 8;
      if (lim < nfull) nfull = lim;
    end
    if (use_model && valid) begin
      for (int i = 0; i < nfull; i++) begin
        a4 = 4'((int'(cmd[3:0]) + i) % 16);
        if (cmd[7]) begin
          exp_wr.push_back({a4, tx_bytes[i+1]});
          shadow[a4] = tx_bytes[i+1];
        end else begin
          exp_rd.push_back(shadow[a4]);
        end
      end
    end
    for (int i = 0; i < 16; i++) rxb[i] = 8'h00;
    if (is_rd) chk_miso0 = 1'b0;

    spi_cs_n = 1'b0;
    tick(half);
    for (int b = 0; b < nbits; b++) begin
      t = tx_bytes[b/8];
      spi_mosi = t[7 - (b % 8)];
      tick(half);
      if (b == rst_bit) begin
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
      end
      if (b == 4) chk("busy_cmd", 32'(busy), 32'd1);
      if (b == 10) chk("busy_data", 32'(busy), 32'(exp_busy));
      spi_sclk = 1'b1;
      t = rxb[b/8];
      t = {t[6:0], spi_miso};
      rxb[b/8] = t;
      tick(half);
      spi_sclk = 1'b0;
    end
    tick(half);
    spi_cs_n = 1'b1;
    tick(3);
    chk("busy_after_cs", 32'(busy), 32'd0);
    tick(4);
    if (is_rd) begin
      for (int i = 0; exp_rd.size() > 0; i++) begin
        chk($sformatf("miso_byte%0d", i), 32'(rxb[i+1]), 32'(exp_rd.pop_front()));
      end
      chk_miso0 = 1'b1;
    end
    chk("pending_writes", 32'(exp_wr.size()), 32'd0);
  endtask

  initial begin
    logic [7:0] cmd;
    int nd;
    int part;

    for (int i = 0; i < 16; i++) mem_init[i] = 8'($urandom_range(0, 255));
    mem_init[15] = 8'h5A;
    mem_init[0]  = 8'hC3;
    for (int i = 0; i < 16; i++) shadow[i] = mem_init[i];

    // Reset with SPI pins toggling.
    rst_n    = 1'b0;
    spi_sclk = 1'($urandom_range(0, 1));
    spi_cs_n = 1'($urandom_range(0, 1));
    spi_mosi = 1'($urandom_range(0, 1));
    tick(1);
    mon_en   = 1'b1;
    spi_sclk = 1'($urandom_range(0, 1));
    spi_cs_n = 1'($urandom_range(0, 1));
    spi_mosi = 1'($urandom_range(0, 1));
    tick(1);
    chk("rst_miso", 32'(spi_miso), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    spi_sclk = 1'b0;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    mem_load = 1'b0;
    rst_n    = 1'b1;
    tick(1);
    chk_miso0 = 1'b1;
    tick(5);

    // Burst read with wrap from preloaded contents.
    tx_bytes = '{8'h0F, 8'h00, 8'h00};
    exp_rd.push_back(8'h5A);
    exp_rd.push_back(8'hC3);
    run_frame(24, 6, -1, 1'b1, 1'b0);

    // Single write.
    tx_bytes = '{8'h83, 8'hA5};
    exp_wr.push_back({4'd3, 8'hA5});
    shadow[3] = 8'hA5;
    run_frame(16, 5, -1, 1'b1, 1'b0);

    // Burst write wrapping 15 -> 0.
    tx_bytes = '{8'h8E, 8'h11, 8'h22, 8'h33};
    exp_wr.push_back({4'd14, 8'h11});
    exp_wr.push_back({4'd15, 8'h22});
    exp_wr.push_back({4'd0, 8'h33});
    shadow[14] = 8'h11;
    shadow[15] = 8'h22;
    shadow[0]  = 8'h33;
    run_frame(32, 4, -1, 1'b1, 1'b0);

    // Read back the burst.
    tx_bytes = '{8'h0E, 8'hFF, 8'hFF, 8'hFF};
    exp_rd.push_back(8'h11);
    exp_rd.push_back(8'h22);
    exp_rd.push_back(8'h33);
    run_frame(32, 4, -1, 1'b1, 1'b0);

    // Reserved bits set: ignored frame.
    tx_bytes = '{8'hF2, 8'hFF};
    run_frame(16, 5, -1, 1'b0, 1'b0);

    // Abort after 5 data bits.
    tx_bytes = '{8'h85, 8'hFF};
    run_frame(13, 5, -1, 1'b1, 1'b0);

    // Reset during a write data byte, chip select held low.
    tx_bytes = '{8'h84, 8'h77, 8'h88};
    run_frame(24, 5, 12, 1'b1, 1'b0);

    tx_bytes = '{8'h84, 8'h99};
    exp_wr.push_back({4'd4, 8'h99});
    shadow[4] = 8'h99;
    run_frame(16, 5, -1, 1'b1, 1'b0);

    tx_bytes = '{8'h04, 8'h00};
    exp_rd.push_back(8'h99);
    run_frame(16, 5, -1, 1'b1, 1'b0);

    // Randomized frames checked against the model.
    for (int f = 0; f < 40; f++) begin
      tx_bytes.delete();
      cmd = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 5) != 0) cmd[6:4] = 3'b000;
      nd   = $urandom_range(0, 4);
      part = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      tx_bytes.push_back(cmd);
      for (int i = 0; i <= nd; i++) tx_bytes.push_back(8'($urandom_range(0, 255)));
      run_frame(8 + 8 * nd + part, $urandom_range(4, 7), -1, (cmd[6:4] == 3'b000), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_spi_bridge.md
# mem_spi_bridge

SPI mode-0 slave that lets an external host load and read back the 16-byte DFF memory. Sits directly upstream of the memory: it decodes serial command frames and drives the memory's 4-bit address, 8-bit write data and write-enable, and captures the memory's registered read data for shift-out. Supports single-byte and auto-incrementing burst transfers with address wrap.

## Interface
- `ADDR_BITS`, 4: memory address width; memory depth is 2^ADDR_BITS bytes.
- `clk`  in  1  system clock; all logic is in this domain.
- `rst_n`  in  1  reset; synchronous, active-low.
- `spi_sclk`  in  1  SPI clock, asynchronous to `clk`; idles low.
- `spi_cs_n`  in  1  chip select, asynchronous, active-low; frame delimiter.
- `spi_mosi`  in  1  serial data in, MSB first.
- `spi_miso`  out  1  serial data out, MSB first; no tristate.
- `mem_addr`  out  ADDR_BITS  memory address.
- `mem_wdata`  out  8  memory write data.
- `mem_we`  out  1  memory write enable, one-cycle pulse.
- `mem_rdata`  in  8  memory registered read data.
- `busy`  out  1  high while a frame is accepted and in progress.

## Operation
- Input sync: `spi_sclk`, `spi_cs_n` and `spi_mosi` each pass through a 2-flop synchronizer. Reset values are 0, 1 and 0. Edges are detected on the synchronized `spi_sclk` (rise and fall strobes).
- Frame: `spi_cs_n` falls, then a command byte, then N ≥ 0 data bytes, then `spi_cs_n` rises.
- Command byte:
  - bit7 = 1 for write, 0 for read.
  - bits6:4 are reserved and must be 000.
  - bits3:0 are the start address.
- States:
  - IDLE to CMD on synchronized `cs_n` falling.
  - CMD to WR or RD after the 8th rising `sclk` edge, if the reserved bits are 000.
  - CMD to IGNORE if the reserved bits are nonzero.
  - Any state to IDLE when synchronized `cs_n` is high.
- MOSI is sampled on synchronized `sclk` rise. A 3-bit bit counter is cleared on entering CMD and wraps every 8 bits.
- WR: after each completed data byte:
  - `mem_wdata` ← byte and `mem_we` = 1 for exactly one cycle, with `mem_addr` = current address.
  - On the following cycle the address increments modulo 2^ADDR_BITS (15 → 0).
- RD: on entering RD, and after each completed data byte (the address increments first, wrapping 15 → 0):
  - `mem_addr` is updated.
  - `mem_rdata` is captured into the TX shift register exactly 2 cycles after the `mem_addr` update (the memory has a registered read).
  - MISO drives the TX MSB from the next synchronized `sclk` fall, then shifts one bit per fall.
  - MOSI content during RD is ignored.
- IGNORE: no `mem_we`, MISO held 0, until `cs_n` rises.
- `spi_miso` = 0 in IDLE, CMD, WR and IGNORE.
- `busy` = 1 in CMD, WR and RD; 0 in IDLE and IGNORE.
- Abort: `cs_n` rising mid-byte discards the partial byte, issues no write, and leaves memory unchanged. A completed byte whose write pulse is already issued stands.
- `mem_we` never asserts outside WR.
- Reset mid-frame: all state and outputs take their reset values. If `spi_cs_n` is still low when reset releases, the remainder of that frame is ignored; a new frame requires a `cs_n` high-then-low.

## Timing
- Reset values: `spi_miso` = 0, `mem_addr` = 0, `mem_wdata` = 0, `mem_we` = 0, `busy` = 0, state IDLE.
- SPI input to internal strobe: 3 `clk` cycles (2 sync + 1 edge detect).
- `spi_sclk` high and low phases must each be ≥ 4 `clk` periods. `cs_n` setup before the first rise and hold after the last fall must each be ≥ 4 `clk` periods.
- Write: `mem_we` asserts 1 cycle after the rise strobe of bit 0 of the data byte.
- Read: `mem_addr` updates 1 cycle after the rise strobe of the last bit of the previous byte. Data is loaded at +2 cycles, before the next fall strobe (guaranteed by the ≥ 4 cycle phase rule).
- Back-to-back frames: `cs_n` high for ≥ 4 `clk` cycles between frames.

## Test plan
- Reset: hold `rst_n` = 0 for 2 cycles with the SPI pins toggling -> all outputs 0, `mem_we` never pulses.
- Single write: frame 0x83, 0xA5 -> one `mem_we` pulse with `mem_addr` = 3 and `mem_wdata` = 0xA5; `busy` falls within 3 cycles of `cs_n` high.
- Burst write with wrap: frame 0x8E, 0x11, 0x22, 0x33 -> writes at addr 14, 15, 0 with data 0x11, 0x22, 0x33; no other `mem_we`.
- Burst read: with a memory model preloaded addr15 = 0x5A and addr0 = 0xC3, frame 0x0F plus 2 dummy bytes -> MISO shifts 0x5A then 0xC3, MSB first, valid on every `sclk` rise.
- Reserved bits and abort: frame 0xF2, 0xFF -> no write, MISO 0, `busy` 0. Separately, frame 0x85 followed by only 5 data bits then `cs_n` high -> no `mem_we`, and state returns to IDLE.
- Reset mid-frame: assert `rst_n` during a write data byte with `cs_n` held low -> no write. The rest of that frame is ignored, and the next full frame works.
